// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 arbiter with a single registered output stage and source index.
// Optional burst locking is enabled by defining MUX_ARB_BURST_LOCK_EN.
module mux_rr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int GW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic [GW-1:0]    out_grant,
  input  logic             out_ready
);

  logic [GW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [GW-1:0] out_grant_q, out_grant_d;

  logic [GW-1:0] sel_s;
  logic          found_s;
  logic [W-1:0]  sel_data_s;
  logic          sel_last_s;
  logic          can_load_s;
  logic          accept_s;
  logic [N-1:0]  in_ready_s;
  logic          lock_active_s;
  logic [GW-1:0] lock_idx_s;
  logic          elig_s;
  int            dist_s;
  int            best_s;

`ifdef MUX_ARB_BURST_LOCK_EN
  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} lock_state_e;
  lock_state_e   lock_state_q;
  logic [GW-1:0] lock_idx_q;

  assign lock_active_s = (lock_state_q == ST_LOCKED);
  assign lock_idx_s    = lock_idx_q;
`else
  assign lock_active_s = 1'b0;
  assign lock_idx_s    = {GW{1'b0}};
`endif

  // Pick the valid requester closest after ptr (distance 0 means ptr+1); a lock restricts to lock_idx.
  always_comb begin
    sel_s      = ptr_q;
    found_s    = 1'b0;
    sel_data_s = {W{1'b0}};
    sel_last_s = 1'b0;
    best_s     = N;
    dist_s     = 0;
    elig_s     = 1'b0;
    for (int j = 0; j < N; j++) begin
      dist_s = (j + N - 1 - int'(ptr_q)) % N;
      if (lock_active_s) begin
        elig_s = (j == int'(lock_idx_s));
      end else begin
        elig_s = 1'b1;
      end
      if (in_valid[j] && elig_s && (dist_s < best_s)) begin
        best_s     = dist_s;
        found_s    = 1'b1;
        sel_s      = GW'(j);
        sel_data_s = in_data[j*W +: W];
        sel_last_s = in_last[j];
      end else begin
        best_s     = best_s;
      end
    end
  end

  assign can_load_s = !out_valid_q || out_ready;
  assign accept_s   = can_load_s && found_s && !rst;

  // One-hot ready for the selected requester only; never depends on data.
  always_comb begin
    in_ready_s = {N{1'b0}};
    for (int j = 0; j < N; j++) begin
      in_ready_s[j] = accept_s && (sel_s == GW'(j));
    end
  end

  assign in_ready = in_ready_s;

  // Output stage next state: load on accept, otherwise drain while keeping payload.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_grant_d = out_grant_q;
    if (accept_s) begin
      ptr_d       = sel_s;
      out_valid_d = 1'b1;
      out_data_d  = sel_data_s;
      out_last_d  = sel_last_s;
      out_grant_d = sel_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; ptr resets to N-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= GW'(N - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= {W{1'b0}};
      out_last_q  <= 1'b0;
      out_grant_q <= {GW{1'b0}};
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_grant_q <= out_grant_d;
    end
  end

`ifdef MUX_ARB_BURST_LOCK_EN
  // Burst lock FSM: a non-last beat pins the channel to its source until its last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_q <= ST_UNLOCKED;
      lock_idx_q   <= {GW{1'b0}};
    end else begin
      case (lock_state_q)
        ST_UNLOCKED: begin
          if (accept_s && !sel_last_s) begin
            lock_state_q <= ST_LOCKED;
            lock_idx_q   <= sel_s;
          end else begin
            lock_state_q <= ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (accept_s && sel_last_s) begin
            lock_state_q <= ST_UNLOCKED;
          end else begin
            lock_state_q <= ST_LOCKED;
          end
        end
        default: lock_state_q <= ST_UNLOCKED;
      endcase
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_grant = out_grant_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, burst sequence, random run vs model.
module tb_mux_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int GW = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [GW-1:0]    out_grant;
  logic             out_ready;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_arbiter #(.N(N), .W(W), .GW(GW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_grant(out_grant), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_g;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                              input logic o, input logic [3:0] rdy, input logic ov,
                              input logic [1:0] g, input logic [7:0] ed);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.ordy = o;
    t.exp_rdy = rdy; t.exp_ov = ov; t.exp_g = g; t.exp_d = ed;
    return t;
  endfunction

  // Reference model state (abstract: last-served index, held beat, lock)
  int          m_ptr;
  logic        m_ov;
  logic [7:0]  m_od;
  logic        m_ol;
  int          m_og;
  logic        m_locked;
  int          m_lock;
  logic        pv[N];
  logic [7:0]  pd[N];
  logic        pl[N];

  function automatic int model_sel();
    if (m_locked) begin
      return pv[m_lock] ? m_lock : -1;
    end
    for (int k = 1; k <= N; k++) begin
      if (pv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  localparam logic [31:0] DFLT = 32'hA3A2A1A0;
  localparam logic [31:0] HOLD = 32'hA3A255A0;

  initial begin
    int exp_g[5];
    int r1_sent;
    int sel;
    logic [3:0] exp_rdy;
    logic [7:0] exp_d;

    rst = 1'b1; in_valid = 4'h0; in_data = DFLT; in_last = 4'hF; out_ready = 1'b1;

    tbl.push_back(mk(1'b1, 4'b0000, DFLT, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 4'b0000, DFLT, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b0, 4'b1111, DFLT, 1'b1, 4'(4'b0001 << (i % 4)), 1'b1, 2'(i % 4), 8'(8'hA0 + (i % 4))));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 4'b0100, DFLT, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2));
    tbl.push_back(mk(1'b0, 4'b0000, DFLT, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2));
    tbl.push_back(mk(1'b0, 4'b0010, HOLD, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h55));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 4'b0010, DFLT, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h55));
    tbl.push_back(mk(1'b0, 4'b0010, DFLT, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1));
    tbl.push_back(mk(1'b0, 4'b0000, DFLT, 1'b1, 4'b0000, 1'b0, 2'd1, 8'hA1));
    tbl.push_back(mk(1'b0, 4'b0100, DFLT, 1'b0, 4'b0100, 1'b1, 2'd2, 8'hA2));
    tbl.push_back(mk(1'b1, 4'b1100, DFLT, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00));
    tbl.push_back(mk(1'b0, 4'b1111, DFLT, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));
    tbl.push_back(mk(1'b0, 4'b0000, DFLT, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; in_valid = tbl[i].valid; in_data = tbl[i].data; out_ready = tbl[i].ordy;
      #3;
      check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
      check($sformatf("vec%0d out_grant", i), 64'(out_grant), 64'(tbl[i].exp_g));
      check($sformatf("vec%0d out_data", i), 64'(out_data), 64'(tbl[i].exp_d));
    end

    // Burst: requester 1 sends three beats (last on third) while requester 3 stays valid
`ifdef MUX_ARB_BURST_LOCK_EN
    exp_g = '{1, 1, 1, 3, 3};
`else
    exp_g = '{1, 3, 1, 3, 1};
`endif
    r1_sent = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid  = {1'b1, 1'b0, (r1_sent < 3), 1'b0};
      in_data   = {8'h33, 8'h00, 8'(8'h10 + r1_sent), 8'h00};
      in_last   = {1'b1, 1'b1, (r1_sent == 2), 1'b1};
      out_ready = 1'b1;
      exp_d = (exp_g[c] == 1) ? 8'(8'h10 + r1_sent) : 8'h33;
      @(posedge clk); #1;
      check($sformatf("burst%0d grant", c), 64'(out_grant), 64'(exp_g[c]));
      check($sformatf("burst%0d data", c), 64'(out_data), 64'(exp_d));
      if (exp_g[c] == 1) r1_sent++;
    end

    // Random run against the model; producers hold each beat until accepted
    for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pd[i] = 8'h00; pl[i] = 1'b1; end
    m_ptr = N - 1; m_ov = 1'b0; m_od = 8'h00; m_ol = 1'b0; m_og = 0; m_locked = 1'b0; m_lock = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = (cyc == 0) || ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom_range(0, 2) != 0)) begin
          pv[i] = 1'b1; pd[i] = 8'($urandom); pl[i] = ($urandom_range(0, 3) != 0);
        end
      end
      for (int i = 0; i < N; i++) begin
        in_valid[i] = pv[i]; in_data[i*W +: W] = pd[i]; in_last[i] = pl[i];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #3;
      sel = model_sel();
      exp_rdy = (!rst && sel >= 0 && (!m_ov || out_ready)) ? 4'(4'b0001 << sel) : 4'b0000;
      check("rand in_ready", 64'(in_ready), 64'(exp_rdy));
      @(posedge clk); #1;
      if (rst) begin
        m_ptr = N - 1; m_ov = 1'b0; m_od = 8'h00; m_ol = 1'b0; m_og = 0; m_locked = 1'b0;
      end else if (exp_rdy != 4'b0000) begin
        m_ov = 1'b1; m_od = pd[sel]; m_ol = pl[sel]; m_og = sel; m_ptr = sel;
`ifdef MUX_ARB_BURST_LOCK_EN
        if (m_locked && pl[sel]) m_locked = 1'b0;
        else if (!m_locked && !pl[sel]) begin m_locked = 1'b1; m_lock = sel; end
`endif
        pv[sel] = 1'b0;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      check("rand out_valid", 64'(out_valid), 64'(m_ov));
      check("rand out_grant", 64'(out_grant), 64'(m_og));
      check("rand out_data", 64'(out_data), 64'(m_od));
      check("rand out_last", 64'(out_last), 64'(m_ol));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one W-bit output channel between N requesters by driving the select of an N:1 data mux and registering the chosen beat into a single output stage. It sits between several valid/ready producers and one valid/ready consumer, so that a shared downstream resource sees one stream with the source index attached. It gives full throughput, one beat per cycle, when the consumer is always ready. Burst locking is optional.

## Interface
- N, default 4: number of requesters (N >= 2).
- W, default 8: data width per requester.
- GW, default $clog2(N): width of the grant index.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  N  per-requester beat valid.
- in_data  input  N*W  flattened data; requester i occupies bits [i*W +: W].
- in_last  input  N  per-requester end-of-burst flag (used only with MUX_ARB_BURST_LOCK_EN).
- in_ready  output  N  per-requester accept; at most one bit is high per cycle.
- out_valid  output  1  output stage holds a beat.
- out_data  output  W  registered data of the held beat.
- out_last  output  1  registered in_last of the held beat.
- out_grant  output  GW  index of the requester that produced the held beat.
- out_ready  input  1  consumer accepts the held beat.

## Operation
- can_load = !out_valid || out_ready.
- Arbitration is combinational:
  - Search in_valid starting at index ptr+1, modulo N, wrapping.
  - The first set bit is sel.
  - found = |in_valid.
- in_ready[i] = can_load && found && (sel == i) && !rst.
- Accept occurs when in_valid[sel] && in_ready[sel].
- On accept:
  - out_data <= in_data[sel]
  - out_last <= in_last[sel]
  - out_grant <= sel
  - out_valid <= 1
  - ptr <= sel
- When out_valid && out_ready and there is no accept: out_valid <= 0. Data, last and grant hold their values.
- Simultaneous drain and accept: the new beat replaces the old one in the same edge, and out_valid stays 1.
- Fairness: after requester k is served, every other requester with valid held high is served before k is served again.
- N that is not a power of 2: the search wraps at N. Indices >= N are never granted.
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0, out_grant = 0.
  - ptr = N-1, so requester 0 has first priority.
  - in_ready = 0.
  - Lock state = UNLOCKED.
- Reset mid-transfer: the held beat is discarded, and no in_ready is high in the reset cycle.

## Timing
- Latency: a beat accepted at edge t appears on out_* immediately after t (one cycle).
- Throughput: one beat per cycle while out_ready = 1.
- in_ready depends combinationally on in_valid, out_ready and state, but not on in_data.
- Producers must hold in_valid, in_data and in_last stable until accepted.
- out_* are held stable while out_valid && !out_ready.

## Configuration
- Macro: MUX_ARB_BURST_LOCK_EN.
- Defined: a two-state FSM of UNLOCKED and LOCKED.
  - UNLOCKED: arbitration as above. An accept with in_last[sel] = 0 goes to LOCKED with lock_idx = sel.
  - LOCKED: sel is forced to lock_idx, and all other requesters see in_ready = 0.
  - LOCKED: if in_valid[lock_idx] = 0, the channel idles (bubble). No other source is granted.
  - LOCKED: an accept with in_last = 1 returns to UNLOCKED and sets ptr to lock_idx.
  - A single-beat burst (last = 1 on the first beat) never enters LOCKED.
- Not defined:
  - There is no FSM, and every beat is arbitrated independently.
  - in_last is passed through to out_last only.

## Test plan
- Reset, then all in_valid = 0 for 5 cycles -> out_valid = 0, in_ready = 0, out_grant = 0.
- N = 4, all in_valid = 1, out_ready = 1, data[i] = 8'hA0+i, for 8 cycles -> out_grant sequence 0,1,2,3,0,1,2,3 with matching data; one beat per cycle.
- Only requester 2 valid for 4 cycles with out_ready = 1 -> 4 consecutive beats on out_grant = 2; in_ready[2] = 1 every cycle.
- out_ready = 0 for 3 cycles while holding data 8'h55 -> out_data stays 8'h55, and all in_ready = 0 until out_ready returns to 1.
- Burst with the macro defined: requester 1 sends 3 beats (last on beat 3) while requester 3 is valid throughout -> grants 1,1,1 then 3. Without the macro -> grants 1,3,1,3,1.
- Reset asserted while out_valid = 1 and out_ready = 0 -> out_valid = 0 on the next edge, and ptr restarts so requester 0 is served first.
